// File: rtl/core_mmio_bridge_pkg.sv
// Shared decode constants, STATUS layout and the select enum for core_mmio_bridge.
package core_mmio_pkg;

  localparam logic [3:0] OFS_TX     = 4'h0;
  localparam logic [3:0] OFS_RX     = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_NE      = 2;
  localparam int ST_TX_CNT_LSB = 8;
  localparam int ST_RX_CNT_LSB = 16;
  localparam int ST_CNT_W      = 8;

  typedef enum logic [2:0] {
    SEL_MEM,
    SEL_TX,
    SEL_RX,
    SEL_STATUS,
    SEL_NONE
  } sel_e;

  // Unaligned offsets and 0xC fall through to SEL_NONE: read 0, write dropped.
  function automatic sel_e mmio_decode(input logic hit, input logic [3:0] ofs);
    if (!hit) return SEL_MEM;
    case (ofs)
      OFS_TX:     return SEL_TX;
      OFS_RX:     return SEL_RX;
      OFS_STATUS: return SEL_STATUS;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/core_mmio_bridge_if.sv
// Core load/store port, dmem port and TX/RX byte streams of core_mmio_bridge.
interface core_mmio_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              stall;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output mem_write, mem_read, addr, write_data, dmem_rdata, tx_ready, rx_data, rx_valid,
    input  read_data, stall, dmem_we, dmem_addr, dmem_wdata, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  mem_write, mem_read, addr, write_data, dmem_rdata, tx_ready, rx_data, rx_valid,
    output read_data, stall, dmem_we, dmem_addr, dmem_wdata, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/core_mmio_bridge_byte_fifo.sv
// byte_fifo: power-of-two deep byte queue with occupancy count; dout reads 0 when empty.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  // Masking keeps dout at 0 after reset without clearing the storage array.
  assign dout   = empty ? 8'h00 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/core_mmio_bridge.sv
// Core<->dmem bridge with a 16-byte MMIO window: TX FIFO, RX FIFO and STATUS.
// Build option MMIO_RX_EN: when defined, the RX FIFO, rx_* handshake and RX load stall exist.
module core_mmio_bridge
  import core_mmio_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                TX_DEPTH  = 16,
  parameter int                RX_DEPTH  = 16,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 32'hFFFF_0000
) (
  input logic               clk,
  input logic               rst,
  core_mmio_bridge_if.slave bus
);
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic              w_hit;
  sel_e              w_sel;
  logic              w_store;
  logic              w_load;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rdata;

  logic              w_tx_push;
  logic              w_tx_pop;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic [7:0]        w_tx_dout;
  logic [TX_CW-1:0]  w_tx_cnt;
  logic              w_tx_stall;

  logic              w_rx_full;
  logic              w_rx_empty;
  logic [7:0]        w_rx_dout;
  logic [RX_CW-1:0]  w_rx_cnt;
  logic              w_rx_stall;

  assign w_hit   = (bus.addr[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
  assign w_sel   = mmio_decode(w_hit, bus.addr[3:0]);
  // A simultaneous read and write strobe is a store.
  assign w_store = bus.mem_write;
  assign w_load  = bus.mem_read & ~bus.mem_write;

  assign bus.dmem_we    = (w_sel == SEL_MEM) & bus.mem_write;
  assign bus.dmem_addr  = bus.addr;
  assign bus.dmem_wdata = bus.write_data;

  // Full is judged on registered state, so a same-cycle pop does not unblock the store.
  assign w_tx_stall = (w_sel == SEL_TX) & w_store & w_tx_full;
  assign w_tx_push  = (w_sel == SEL_TX) & w_store & ~w_tx_full;
  assign w_tx_pop   = bus.tx_ready & ~w_tx_empty;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   (bus.write_data[7:0]),
    .dout  (w_tx_dout),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_cnt)
  );

  assign bus.tx_valid = ~w_tx_empty;
  assign bus.tx_data  = w_tx_dout;

`ifdef MMIO_RX_EN
  logic w_rx_push;
  logic w_rx_pop;

  assign w_rx_push    = bus.rx_valid & ~w_rx_full;
  assign w_rx_pop     = (w_sel == SEL_RX) & w_load & ~w_rx_empty;
  assign w_rx_stall   = (w_sel == SEL_RX) & w_load & w_rx_empty;
  assign bus.rx_ready = ~w_rx_full;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .din   (bus.rx_data),
    .dout  (w_rx_dout),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_cnt)
  );
`else
  // No RX path: the queue looks permanently empty and RX loads never stall.
  assign w_rx_full    = 1'b0;
  assign w_rx_empty   = 1'b1;
  assign w_rx_dout    = 8'h00;
  assign w_rx_cnt     = '0;
  assign w_rx_stall   = 1'b0;
  assign bus.rx_ready = 1'b0;
`endif

  assign bus.stall = w_tx_stall | w_rx_stall;

  always_comb begin
    w_status                                = '0;
    w_status[ST_TX_FULL]                    = w_tx_full;
    w_status[ST_TX_EMPTY]                   = w_tx_empty;
    w_status[ST_RX_NE]                      = ~w_rx_empty;
    w_status[ST_TX_CNT_LSB +: ST_CNT_W]     = ST_CNT_W'(w_tx_cnt);
    w_status[ST_RX_CNT_LSB +: ST_CNT_W]     = ST_CNT_W'(w_rx_cnt);
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_MEM:    w_rdata = bus.dmem_rdata;
      SEL_RX:     if (w_load && !w_rx_empty) w_rdata[7:0] = w_rx_dout;
      SEL_STATUS: w_rdata = w_status;
      default:    w_rdata = '0;
    endcase
  end

  assign bus.read_data = w_rdata;
endmodule

// File: tb/tb_core_mmio_bridge.sv
// Directed, table-driven bench for core_mmio_bridge plus hand sequences for FIFO corners.
module tb_core_mmio_bridge;
`ifdef MMIO_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif
  localparam logic [31:0] MEMRD = 32'h1234_5678;
  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_RX  = 32'hFFFF_0004;
  localparam logic [31:0] A_ST  = 32'hFFFF_0008;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  core_mmio_bridge_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  core_mmio_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        txr;
    logic [31:0] exp_rd;
    logic        exp_stall;
    logic        exp_we;
    logic        exp_txv;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t       tv[14];
  logic [7:0] q[$];

  function automatic vec_t mk(input logic wr, rd, input logic [31:0] a, wd, input logic txr,
                              input logic [31:0] erd, input logic est, ewe, etv,
                              input logic [7:0] etd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.txr = txr;
    v.exp_rd = erd; v.exp_stall = est; v.exp_we = ewe; v.exp_txv = etv; v.exp_txd = etd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, rd, input logic [31:0] a, wd, input logic txr,
                       input logic rxv, input logic [7:0] rxd);
    @(negedge clk);
    bus.mem_write  = wr;
    bus.mem_read   = rd;
    bus.addr       = a;
    bus.write_data = wd;
    bus.tx_ready   = txr;
    bus.rx_valid   = rxv;
    bus.rx_data    = rxd;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.mem_write = 1'b0; bus.mem_read = 1'b0; bus.addr = '0; bus.write_data = '0;
    bus.dmem_rdata = MEMRD; bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;

    //          wr rd addr          wdata          txr  exp_rd        st    we    txv   txd
    tv[0]  = mk(0, 1, A_ST,         32'h0,         0,   32'h0000_0002, 0,   0,    0,    8'h00);
    tv[1]  = mk(1, 0, A_TX,         32'h0000_0041, 0,   32'h0,         0,   0,    0,    8'h00);
    tv[2]  = mk(0, 1, A_ST,         32'h0,         0,   32'h0000_0100, 0,   0,    1,    8'h41);
    tv[3]  = mk(1, 0, 32'h100,      32'hDEAD_BEEF, 0,   MEMRD,         0,   1,    1,    8'h41);
    tv[4]  = mk(1, 0, 32'hFFFF_000C, 32'h99,       0,   32'h0,         0,   0,    1,    8'h41);
    tv[5]  = mk(0, 1, A_ST,         32'h0,         0,   32'h0000_0100, 0,   0,    1,    8'h41);
    tv[6]  = mk(0, 1, A_TX,         32'h0,         0,   32'h0,         0,   0,    1,    8'h41);
    tv[7]  = mk(1, 1, A_TX,         32'h0000_0077, 0,   32'h0,         0,   0,    1,    8'h41);
    tv[8]  = mk(0, 1, 32'hFFFF_0001, 32'h0,        0,   32'h0,         0,   0,    1,    8'h41);
    tv[9]  = mk(0, 1, A_RX,         32'h0,         0,   32'h0,         RX_EN, 0,  1,    8'h41);
    tv[10] = mk(0, 0, 32'h0,        32'h0,         1,   MEMRD,         0,   0,    1,    8'h41);
    tv[11] = mk(0, 1, A_ST,         32'h0,         0,   32'h0000_0100, 0,   0,    1,    8'h77);
    tv[12] = mk(0, 0, 32'h0,        32'h0,         1,   MEMRD,         0,   0,    1,    8'h77);
    tv[13] = mk(0, 1, A_ST,         32'h0,         0,   32'h0000_0002, 0,   0,    0,    8'h00);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'(RX_EN));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(tv[i].wr, tv[i].rd, tv[i].addr, tv[i].wdata, tv[i].txr, 1'b0, 8'h00);
      chk($sformatf("v%0d_read_data", i), bus.read_data, tv[i].exp_rd);
      chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(tv[i].exp_stall));
      chk($sformatf("v%0d_dmem_we", i), 32'(bus.dmem_we), 32'(tv[i].exp_we));
      chk($sformatf("v%0d_dmem_addr", i), bus.dmem_addr, tv[i].addr);
      chk($sformatf("v%0d_dmem_wdata", i), bus.dmem_wdata, tv[i].wdata);
      chk($sformatf("v%0d_tx_valid", i), 32'(bus.tx_valid), 32'(tv[i].exp_txv));
      chk($sformatf("v%0d_tx_data", i), 32'(bus.tx_data), 32'(tv[i].exp_txd));
    end

    // Fill TX, stall on the 17th store, release with a one-cycle pop.
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, A_TX, 32'h10 + 32'(i), 0, 0, 8'h00);
      chk($sformatf("fill%0d_stall", i), 32'(bus.stall), 32'h0);
      q.push_back(8'(8'h10 + i));
    end
    drive(1, 0, A_TX, 32'hEE, 0, 0, 8'h00);
    chk("full_stall", 32'(bus.stall), 32'h1);
    drive(1, 0, A_TX, 32'hEE, 1, 0, 8'h00);
    chk("full_pop_still_stall", 32'(bus.stall), 32'h1);
    chk("full_pop_head", 32'(bus.tx_data), 32'(q[0]));
    void'(q.pop_front());
    drive(1, 0, A_TX, 32'hEE, 0, 0, 8'h00);
    chk("retry_no_stall", 32'(bus.stall), 32'h0);
    q.push_back(8'hEE);
    drive(0, 1, A_ST, 32'h0, 0, 0, 8'h00);
    chk("full_status", bus.read_data, 32'h0000_1001);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 32'h0, 32'h0, 1, 0, 8'h00);
      chk($sformatf("drain%0d_valid", i), 32'(bus.tx_valid), 32'h1);
      chk($sformatf("drain%0d_data", i), 32'(bus.tx_data), 32'(q.pop_front()));
    end
    drive(0, 0, 32'h0, 32'h0, 0, 0, 8'h00);
    chk("drained_valid", 32'(bus.tx_valid), 32'h0);

    // Mid-operation reset drops queued bytes asynchronously.
    for (int i = 0; i < 5; i++) drive(1, 0, A_TX, 32'h61 + 32'(i), 0, 0, 8'h00);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 8'h00);
    chk("pre_rst_valid", 32'(bus.tx_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.tx_valid), 32'h0);
    chk("async_rst_data", 32'(bus.tx_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, A_ST, 32'h0, 0, 0, 8'h00);
    chk("post_rst_status", bus.read_data, 32'h0000_0002);

`ifdef MMIO_RX_EN
    drive(0, 1, A_RX, 32'h0, 0, 1, 8'h5A);
    chk("rx_empty_stall", 32'(bus.stall), 32'h1);
    chk("rx_empty_rdata", bus.read_data, 32'h0);
    drive(0, 1, A_ST, 32'h0, 0, 0, 8'h00);
    chk("rx_one_status", bus.read_data, 32'h0001_0006);
    drive(0, 1, A_RX, 32'h0, 0, 0, 8'h00);
    chk("rx_load_data", bus.read_data, 32'h0000_005A);
    chk("rx_load_stall", 32'(bus.stall), 32'h0);
    drive(0, 1, A_ST, 32'h0, 0, 0, 8'h00);
    chk("rx_drained_status", bus.read_data, 32'h0000_0002);
    for (int i = 0; i < 16; i++) drive(0, 0, 32'h0, 32'h0, 0, 1, 8'(i));
    drive(0, 1, A_ST, 32'h0, 0, 0, 8'h00);
    chk("rx_full_ready", 32'(bus.rx_ready), 32'h0);
    chk("rx_full_status", bus.read_data, 32'h0010_0006);
`else
    drive(0, 1, A_RX, 32'h0, 0, 1, 8'h5A);
    chk("norx_stall", 32'(bus.stall), 32'h0);
    chk("norx_rdata", bus.read_data, 32'h0);
    chk("norx_ready", 32'(bus.rx_ready), 32'h0);
    drive(0, 1, A_ST, 32'h0, 0, 0, 8'h00);
    chk("norx_status", bus.read_data, 32'h0000_0002);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/core_mmio_bridge.md
# core_mmio_bridge

Parametrised data-bus bridge between the RISC-V core's load/store port and data memory. It adds memory-mapped byte I/O through a TX FIFO and an RX FIFO, plus a status register. It also generates a stall request when the core accesses a full TX FIFO or an empty RX FIFO. It sits between the core and dmem in the top-level wrapper, and the UART/host byte streams attach to it.

## Interface
- DATA_W, 32, data bus width (≥ 24)
- ADDR_W, 32, byte address width
- TX_DEPTH, 16, TX FIFO entries (power of two, 2..128)
- RX_DEPTH, 16, RX FIFO entries (power of two, 2..128)
- MMIO_BASE, 32'hFFFF_0000, base of the 16-byte MMIO window (low 4 bits zero)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_write  in  1  core store strobe
- mem_read  in  1  core load strobe
- addr  in  ADDR_W  core byte address (ALU result)
- write_data  in  DATA_W  core store data
- read_data  out  DATA_W  load data to core
- stall  out  1  core must hold the current access
- dmem_we  out  1  data-memory write enable
- dmem_addr  out  ADDR_W  data-memory address
- dmem_wdata  out  DATA_W  data-memory write data
- dmem_rdata  in  DATA_W  data-memory read data
- tx_data  out  8  TX FIFO head byte
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  consumer takes tx_data this cycle
- rx_data  in  8  incoming byte
- rx_valid  in  1  incoming byte present
- rx_ready  out  1  RX FIFO not full

## Operation
- The MMIO window is hit when addr[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4].
  - On a hit, dmem_we = 0.
  - Otherwise dmem_we = mem_write and read_data = dmem_rdata.
- dmem_addr and dmem_wdata always pass through addr and write_data.
- Offset 0x0 TX:
  - Store pushes write_data[7:0] if the TX FIFO is not full; when full, stall = 1 and there is no push.
  - Load returns 0.
- Offset 0x4 RX:
  - Load returns {zeros, head byte} and pops if the RX FIFO is not empty; when empty, stall = 1, there is no pop, and read_data = 0.
  - Store is dropped.
- Offset 0x8 STATUS, read-only:
  - bit0 = tx_full
  - bit1 = tx_empty
  - bit2 = rx_nonempty
  - [15:8] = tx_count
  - [23:16] = rx_count
  - Remaining bits are 0.
- Offset 0xC, and unaligned offsets within the window: reads return 0, writes are dropped, no stall.
- If mem_write and mem_read are both asserted, the access is treated as a store.
- TX pop happens when tx_valid & tx_ready. RX push happens when rx_valid & rx_ready.
- Count width is $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - read_data 0 when not driven by dmem.
  - stall 0.
  - dmem_we 0.
  - tx_valid 0, tx_data 0.
  - rx_ready 1.
  - All counts and pointers 0.
- Combinational paths (same cycle): read_data, stall, dmem_*, and the status word. The status word reflects registered state at the start of the cycle.
- FIFO pushes and pops commit on the rising edge.
  - A byte pushed in cycle N appears on tx_valid/tx_data, and in read data, in cycle N+1.
  - A store to TX is therefore never visible in STATUS in the same cycle.
- Full/empty decisions use the registered state at the start of the cycle:
  - TX full plus a simultaneous external pop still stalls the store; the store succeeds in the next cycle.
  - RX empty plus a simultaneous rx_valid push still stalls the load.
- Simultaneous push and pop on a non-full, non-empty FIFO: the count is unchanged and both pointers advance.
- rx_ready = !rx_full. A push while full is impossible by construction.
- Asserting rst mid-operation clears both FIFOs immediately. Queued bytes are lost and tx_valid drops asynchronously.

## Configuration
- MMIO_RX_EN defined: the RX FIFO, the rx_* ports, and RX stall are present as described.
- MMIO_RX_EN undefined:
  - The RX FIFO is not instantiated and rx_ready is tied to 0.
  - Offset 0x4 loads return 0 without stalling.
  - STATUS bit2 and [23:16] read 0.
  - TX behaviour is unchanged.

## Structure
- Package core_mmio_pkg holds:
  - Offset constants OFS_TX, OFS_RX, OFS_STATUS.
  - STATUS bit/field positions.
  - The decode enum {SEL_MEM, SEL_TX, SEL_RX, SEL_STATUS, SEL_NONE}.
- Sub-module byte_fifo (parameter DEPTH; ports push/pop/din/dout/full/empty/count, clk, rst) is instantiated once for TX and once for RX (RX under MMIO_RX_EN).

## Test plan
- Reset, then load 0xFFFF_0008 → read_data = 0x0000_0002, stall 0, rx_ready 1, tx_valid 0.
- Store 0x41 to 0xFFFF_0000, tx_ready held 0 → next cycle tx_valid 1, tx_data 0x41, STATUS[15:8] = 1.
- 16 stores to TX with tx_ready 0, then a 17th → stall 1 on the 17th. Raise tx_ready for one cycle → the 17th succeeds on the following cycle, and the TX count is 16 again after the pop and push.
- Load from 0xFFFF_0004 with RX empty → stall 1, read_data 0. Drive rx_valid with 0x5A → next cycle the load returns 0x0000_005A, stall 0, and the RX count goes 1→0.
- Store 0xDEAD_BEEF to 0x0000_0100 → dmem_we 1, dmem_addr 0x100, dmem_wdata 0xDEAD_BEEF. Store to 0xFFFF_000C → dmem_we 0, no FIFO change.
- Assert rst with 5 bytes queued → tx_valid 0 immediately, STATUS reads 0x0000_0002 after release. Without MMIO_RX_EN, an RX load returns 0 with stall 0.
